// File: rtl/comparator_sequencer.sv
// Compares two WIDTH-bit unsigned words by stepping one shared external 2-bit
// magnitude comparator slice over the operand bit-pairs, MSB pair first.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for input_START; operands latched when it is accepted
// SCAN  | drive pair idx to the slice, act on its verdict at the edge
// FIN   | result registers valid, output_DONE pulses for this one cycle
module comparator_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             input_CLK,
    input  logic             input_RST,
    input  logic             input_START,
    input  logic [WIDTH-1:0] input_X,
    input  logic [WIDTH-1:0] input_Y,
    output logic             output_A,
    output logic             output_B,
    output logic             output_C,
    output logic             output_D,
    input  logic             input_SLICE_EQ,
    input  logic             input_SLICE_GT,
    input  logic             input_SLICE_LT,
    output logic             output_BUSY,
    output logic             output_DONE,
    output logic             output_EQ,
    output logic             output_GT,
    output logic             output_LT,
    output logic             output_ERR
);

    localparam int NP = WIDTH / 2;
    localparam int IW = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [1:0]       pair_x;
    logic [1:0]       pair_y;
    logic [2:0]       slice_res;
    logic             idx_zero;

    assign slice_res = {input_SLICE_GT, input_SLICE_LT, input_SLICE_EQ};
    assign idx_zero  = (idx == '0);

    // Pair mux reads only the latched operands, never input_X/Y.
    always_comb begin
        pair_x = 2'b00;
        pair_y = 2'b00;
        for (int p = 0; p < NP; p++) begin
            if (idx == IW'(p)) begin
                pair_x = x_q[2*p +: 2];
                pair_y = y_q[2*p +: 2];
            end
        end
    end

    always_ff @(posedge input_CLK) begin
        if (input_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (input_START) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!(slice_res == 3'b001 && !idx_zero)) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        output_BUSY = 1'b0;
        output_DONE = 1'b0;
        output_A    = 1'b0;
        output_B    = 1'b0;
        output_C    = 1'b0;
        output_D    = 1'b0;
        case (state)
            SCAN: begin
                output_BUSY = 1'b1;
                output_A    = pair_x[1];
                output_B    = pair_x[0];
                output_C    = pair_y[1];
                output_D    = pair_y[0];
            end
            FIN:     output_DONE = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, pair index and result registers.
    always_ff @(posedge input_CLK) begin
        if (input_RST) begin
            idx        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            output_EQ  <= 1'b0;
            output_GT  <= 1'b0;
            output_LT  <= 1'b0;
            output_ERR <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (input_START) begin
                        x_q <= input_X;
                        y_q <= input_Y;
                        idx <= IW'(NP - 1);
                    end
                end
                SCAN: begin
                    case (slice_res)
                        3'b100: begin
                            {output_EQ, output_GT, output_LT, output_ERR} <= 4'b0100;
                        end
                        3'b010: begin
                            {output_EQ, output_GT, output_LT, output_ERR} <= 4'b0010;
                        end
                        3'b001: begin
                            if (idx_zero) begin
                                {output_EQ, output_GT, output_LT, output_ERR} <= 4'b1000;
                            end else begin
                                idx <= idx - IW'(1);
                            end
                        end
                        default: begin
                            {output_EQ, output_GT, output_LT, output_ERR} <= 4'b0001;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
